alui_fsm: RTL and testbench



---
 rtl/alui_pkg.sv | 37 +++
 rtl/alui_reg_decode.sv | 41 ++++
 rtl/alui_fsm.sv | 134 +++++++++++++
 tb/tb_alui_fsm.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alui_pkg.sv
// Shared definitions for the ALU-immediate instruction FSM family:
// state encoding, register-select codes and instruction field positions.
package alui_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD1  = 3'd1;
  localparam logic [2:0] ST_LOAD2  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD1  = ST_LOAD1,
    LOAD2  = ST_LOAD2,
    EXEC   = ST_EXEC,
    WRITE  = ST_WRITE,
    FINISH = ST_FINISH,
    HALT   = ST_HALT
  } alui_state_e;

  localparam logic [2:0] REG_G0 = 3'b000;
  localparam logic [2:0] REG_G1 = 3'b001;
  localparam logic [2:0] REG_G2 = 3'b010;
  localparam logic [2:0] REG_G3 = 3'b011;
  localparam logic [2:0] REG_P0 = 3'b100;
  localparam logic [2:0] REG_P1 = 3'b101;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int SEL_MSB = 11;
  localparam int SEL_LSB = 9;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/alui_reg_decode.sv
// Maps a 3-bit register select plus load/drive enables onto the per-register
// Rx_in / Rx_out lines; codes 110/111 select nothing.
module alui_reg_decode
  import alui_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       in_en,
  input  logic       out_en,
  output logic       G0_in,
  output logic       G0_out,
  output logic       G1_in,
  output logic       G1_out,
  output logic       G2_in,
  output logic       G2_out,
  output logic       G3_in,
  output logic       G3_out,
  output logic       P0_in,
  output logic       P0_out,
  output logic       P1_in,
  output logic       P1_out
);

  always_comb begin
    G0_in = 1'b0; G0_out = 1'b0;
    G1_in = 1'b0; G1_out = 1'b0;
    G2_in = 1'b0; G2_out = 1'b0;
    G3_in = 1'b0; G3_out = 1'b0;
    P0_in = 1'b0; P0_out = 1'b0;
    P1_in = 1'b0; P1_out = 1'b0;
    case (sel)
      REG_G0: begin G0_in = in_en; G0_out = out_en; end
      REG_G1: begin G1_in = in_en; G1_out = out_en; end
      REG_G2: begin G2_in = in_en; G2_out = out_en; end
      REG_G3: begin G3_in = in_en; G3_out = out_en; end
      REG_P0: begin P0_in = in_en; P0_out = out_en; end
      REG_P1: begin P1_in = in_en; P1_out = out_en; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alui_fsm.sv
// ALU-immediate instruction sequencer: latches the instruction in IDLE and
// steps through the operand-load / execute / write-back / finish strobes.
//
//   state  | meaning
//   IDLE   | sample instruction word
//   LOAD1  | selected register -> ALU operand 1
//   LOAD2  | immediate -> ALU operand 2
//   EXEC   | latch ALU result
//   WRITE  | ALU result -> selected register
//   FINISH | PC increment, done
//   HALT   | done held until reset
module alui_fsm
  import alui_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fullBitNum,
  output logic        PC_inc,
  output logic        ALUin1,
  output logic        ALUin2,
  output logic        ALU_outlach,
  output logic        ALU_outEN,
  output logic        done,
  output logic        immediate_out,
  output logic [15:0] param2num,
  output logic        G0_in,
  output logic        G0_out,
  output logic        G1_in,
  output logic        G1_out,
  output logic        G2_in,
  output logic        G2_out,
  output logic        G3_in,
  output logic        G3_out,
  output logic        P0_in,
  output logic        P0_out,
  output logic        P1_in,
  output logic        P1_out
);

  alui_state_e state;
  logic [2:0]  sel_q;
  logic [8:0]  imm_q;
  logic        reg_in_en;
  logic        reg_out_en;

  // Opcode belongs to the instruction decoder upstream, not to this block.
  logic unused_opcode;
  assign unused_opcode = ^fullBitNum[OPC_MSB:OPC_LSB];

  // Outputs are registered from the current state, so they trail it by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_q         <= '0;
      imm_q         <= '0;
      PC_inc        <= 1'b0;
      ALUin1        <= 1'b0;
      ALUin2        <= 1'b0;
      ALU_outlach   <= 1'b0;
      ALU_outEN     <= 1'b0;
      done          <= 1'b0;
      immediate_out <= 1'b0;
      reg_in_en     <= 1'b0;
      reg_out_en    <= 1'b0;
    end else begin
      PC_inc        <= 1'b0;
      ALUin1        <= 1'b0;
      ALUin2        <= 1'b0;
      ALU_outlach   <= 1'b0;
      ALU_outEN     <= 1'b0;
      done          <= 1'b0;
      immediate_out <= 1'b0;
      reg_in_en     <= 1'b0;
      reg_out_en    <= 1'b0;
      case (state)
        IDLE: begin
          sel_q <= fullBitNum[SEL_MSB:SEL_LSB];
          imm_q <= fullBitNum[IMM_MSB:IMM_LSB];
          state <= LOAD1;
        end
        LOAD1: begin
          reg_out_en <= 1'b1;
          ALUin1     <= 1'b1;
          state      <= LOAD2;
        end
        LOAD2: begin
          immediate_out <= 1'b1;
          ALUin2        <= 1'b1;
          state         <= EXEC;
        end
        EXEC: begin
          ALU_outlach <= 1'b1;
          state       <= WRITE;
        end
        WRITE: begin
          ALU_outEN <= 1'b1;
          reg_in_en <= 1'b1;
          state     <= FINISH;
        end
        FINISH: begin
          PC_inc <= 1'b1;
          done   <= 1'b1;
          state  <= HALT;
        end
        HALT: begin
          done  <= 1'b1;
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign param2num = {7'b0, imm_q};

  alui_reg_decode u_reg_decode (
    .sel    (sel_q),
    .in_en  (reg_in_en),
    .out_en (reg_out_en),
    .G0_in  (G0_in),
    .G0_out (G0_out),
    .G1_in  (G1_in),
    .G1_out (G1_out),
    .G2_in  (G2_in),
    .G2_out (G2_out),
    .G3_in  (G3_in),
    .G3_out (G3_out),
    .P0_in  (P0_in),
    .P0_out (P0_out),
    .P1_in  (P1_in),
    .P1_out (P1_out)
  );

endmodule

// File: tb/tb_alui_fsm.sv
// Scoreboard bench for alui_fsm: expected per-cycle strobe vectors are queued
// when an instruction is launched and compared as the sequence runs.
module tb_alui_fsm;

  logic        clk;
  logic        rst;
  logic [15:0] fullBitNum;
  logic        PC_inc, ALUin1, ALUin2, ALU_outlach, ALU_outEN, done, immediate_out;
  logic [15:0] param2num;
  logic        G0_in, G0_out, G1_in, G1_out, G2_in, G2_out, G3_in, G3_out;
  logic        P0_in, P0_out, P1_in, P1_out;

  alui_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .fullBitNum    (fullBitNum),
    .PC_inc        (PC_inc),
    .ALUin1        (ALUin1),
    .ALUin2        (ALUin2),
    .ALU_outlach   (ALU_outlach),
    .ALU_outEN     (ALU_outEN),
    .done          (done),
    .immediate_out (immediate_out),
    .param2num     (param2num),
    .G0_in         (G0_in),
    .G0_out        (G0_out),
    .G1_in         (G1_in),
    .G1_out        (G1_out),
    .G2_in         (G2_in),
    .G2_out        (G2_out),
    .G3_in         (G3_in),
    .G3_out        (G3_out),
    .P0_in         (P0_in),
    .P0_out        (P0_out),
    .P1_in         (P1_in),
    .P1_out        (P1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [18:0] vec;
    logic [15:0] p2n;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  pc_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // [18]PC_inc [17]ALUin1 [16]ALUin2 [15]ALU_outlach [14]ALU_outEN [13]done
  // [12]immediate_out [11:0]{G0_in,G0_out,G1_in,G1_out,...,P1_in,P1_out}
  function automatic logic [18:0] obs_vec();
    return {PC_inc, ALUin1, ALUin2, ALU_outlach, ALU_outEN, done, immediate_out,
            G0_in, G0_out, G1_in, G1_out, G2_in, G2_out, G3_in, G3_out,
            P0_in, P0_out, P1_in, P1_out};
  endfunction

  function automatic logic [18:0] exp_vec(input int k, input logic [2:0] sel);
    logic [18:0] v;
    logic [11:0] rin, rout;
    v = '0; rin = '0; rout = '0;
    if (sel < 3'd6) begin
      rin[11 - 2*int'(sel)]  = 1'b1;
      rout[10 - 2*int'(sel)] = 1'b1;
    end
    case (k)
      1: begin v[17] = 1'b1; v[11:0] = rout; end
      2: begin v[16] = 1'b1; v[12] = 1'b1; end
      3: v[15] = 1'b1;
      4: begin v[14] = 1'b1; v[11:0] = rin; end
      5: begin v[18] = 1'b1; v[13] = 1'b1; end
      default: if (k >= 6) v[13] = 1'b1;
    endcase
    return v;
  endfunction

  // Pulse reset, release, let IDLE sample, then queue n expected cycles.
  task automatic start(input logic [15:0] instr, input int n);
    sb_t e;
    fullBitNum = instr;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_strobes", 32'(obs_vec()), 32'h0);
    check_val("rst_p2n", 32'(param2num), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("idle_strobes", 32'(obs_vec()), 32'h0);
    check_val("p2n_latch", 32'(param2num), {23'b0, instr[8:0]});
    pc_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      e.k   = k;
      e.vec = exp_vec(k, instr[11:9]);
      e.p2n = {7'b0, instr[8:0]};
      sb.push_back(e);
    end
  endtask

  task automatic step();
    sb_t e;
    @(posedge clk); #1;
    if (PC_inc) pc_cnt++;
    check_val("bus_onehot", 32'($countones({G0_out, G1_out, G2_out, G3_out, P0_out, P1_out,
                                              immediate_out, ALU_outEN}) <= 1), 32'h1);
    check_val("rin_onehot", 32'($countones({G0_in, G1_in, G2_in, G3_in, P0_in, P1_in}) <= 1), 32'h1);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow no expected entry at %0t", $time);
      return;
    end
    e = sb.pop_front();
    check_val($sformatf("strobes_c%0d", e.k), 32'(obs_vec()), 32'(e.vec));
    check_val($sformatf("p2n_c%0d", e.k), 32'(param2num), 32'(e.p2n));
  endtask

  task automatic run_full(input logic [15:0] instr);
    start(instr, 8);
    for (int i = 0; i < 8; i++) step();
    check_val("pc_once", 32'(pc_cnt), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    fullBitNum = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("por_strobes", 32'(obs_vec()), 32'h0);
    check_val("por_p2n", 32'(param2num), 32'h0);

    run_full(16'b0001_0000_0000_0010);
    run_full({4'h0, 3'b101, 9'h1FF});
    run_full({4'h7, 3'b111, 9'h055});
    run_full({4'h3, 3'b110, 9'h0AA});

    // Instruction word changes mid-sequence; latched copy must hold.
    start({4'hA, 3'b010, 9'h123}, 8);
    step(); step();
    fullBitNum = 16'hFFFF;
    for (int i = 0; i < 6; i++) step();
    check_val("pc_once_chg", 32'(pc_cnt), 32'h1);

    // Reset during EXEC, then a clean restart.
    start({4'h2, 3'b011, 9'h00F}, 8);
    step(); step(); step();
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check_val("abort_strobes", 32'(obs_vec()), 32'h0);
    check_val("abort_p2n", 32'(param2num), 32'h0);
    run_full({4'h2, 3'b011, 9'h00F});

    for (int r = 0; r < 6; r++) run_full(16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
